// File: rtl/osc_clkdiv_mc.sv
// Multi-channel clock divider/gater: N_CH independent divided clocks from CLK.
// Enable, stop and ratio changes take effect only on whole-period boundaries.
module osc_clkdiv_mc #(
    parameter int N_CH  = 4,
    parameter int DIV_W = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_CH-1:0]         ENA,
    input  logic [N_CH*DIV_W-1:0]   DIV,
    output logic [N_CH-1:0]         CLKOUT,
    output logic [N_CH-1:0]         TICK,
    output logic [N_CH-1:0]         ACTIVE
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            state_t             r_st;
            state_t             w_st_nxt;
            logic [DIV_W-1:0]   r_cnt;
            logic [DIV_W-1:0]   r_div_act;
            logic               r_phase;
            logic               r_tick;
            logic [DIV_W-1:0]   w_cnt_nxt;
            logic [DIV_W-1:0]   w_div_nxt;
            logic               w_phase_nxt;
            logic               w_tick_nxt;
            logic [DIV_W-1:0]   w_div_in;
            logic               w_wrap;

            assign w_div_in = DIV[gi*DIV_W +: DIV_W];
            assign w_wrap   = (r_cnt == r_div_act);

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_st      <= S_IDLE;
                    r_cnt     <= '0;
                    r_div_act <= '0;
                    r_phase   <= 1'b0;
                    r_tick    <= 1'b0;
                end else begin
                    r_st      <= w_st_nxt;
                    r_cnt     <= w_cnt_nxt;
                    r_div_act <= w_div_nxt;
                    r_phase   <= w_phase_nxt;
                    r_tick    <= w_tick_nxt;
                end
            end

            // A running channel may only leave RUN at the falling edge that closes a period.
            always_comb begin
                w_st_nxt = r_st;
                case (r_st)
                    S_IDLE:  if (ENA[gi]) w_st_nxt = S_RUN;
                    S_RUN:   if (w_wrap && r_phase && !ENA[gi]) w_st_nxt = S_IDLE;
                    default: w_st_nxt = S_IDLE;
                endcase
            end

            always_comb begin
                w_cnt_nxt   = r_cnt;
                w_div_nxt   = r_div_act;
                w_phase_nxt = r_phase;
                w_tick_nxt  = 1'b0;
                case (r_st)
                    S_IDLE: begin
                        w_cnt_nxt   = '0;
                        w_phase_nxt = 1'b0;
                        if (ENA[gi]) w_div_nxt = w_div_in;
                    end
                    S_RUN: begin
                        if (w_wrap) begin
                            w_cnt_nxt   = '0;
                            w_phase_nxt = ~r_phase;
                            w_tick_nxt  = ~r_phase;
                            // Ratio is only sampled at the period end, so a live DIV change cannot cut a phase short.
                            if (r_phase) w_div_nxt = w_div_in;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        w_cnt_nxt   = '0;
                        w_phase_nxt = 1'b0;
                    end
                endcase
            end

            assign CLKOUT[gi] = r_phase;
            assign TICK[gi]   = r_tick;
            assign ACTIVE[gi] = (r_st == S_RUN);
        end
    endgenerate

endmodule

// File: tb/tb_osc_clkdiv_mc.sv
// Bench for osc_clkdiv_mc: directed stimulus pushes hand-computed edge cycles into
// per-channel queues; a negedge monitor pops and compares whenever an output changes.
module tb_osc_clkdiv_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ena = '0;
    logic [31:0] div = '0;
    logic [3:0]  clkout, tick, active;
    logic [0:0]  ena4 = '0;
    logic [3:0]  div4 = '0;
    logic [0:0]  clkout4, tick4, active4;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    // index 4 is the single channel of the DIV_W=4 instance
    logic [31:0] clk_q[5][$];
    logic [31:0] act_q[5][$];
    logic [4:0]  prev_clk = '0;
    logic [4:0]  prev_act = '0;

    osc_clkdiv_mc #(.N_CH(4), .DIV_W(8)) dut (
        .CLK(clk), .RST(rst), .ENA(ena), .DIV(div),
        .CLKOUT(clkout), .TICK(tick), .ACTIVE(active)
    );

    osc_clkdiv_mc #(.N_CH(1), .DIV_W(4)) dut4 (
        .CLK(clk), .RST(rst), .ENA(ena4), .DIV(div4),
        .CLKOUT(clkout4), .TICK(tick4), .ACTIVE(active4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act_v, input int exp_v);
        n_chk++;
        if (act_v == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act_v, exp_v, cyc);
    endtask

    task automatic push_start(input int ch, input int t);
        act_q[ch].push_back(t);
    endtask

    task automatic push_stop(input int ch, input int t);
        act_q[ch].push_back(t);
    endtask

    task automatic push_period(input int ch, input int t, input int d);
        clk_q[ch].push_back(t + d + 1);
        clk_q[ch].push_back(t + 2 * d + 2);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every change of CLKOUT/ACTIVE must match the next expected edge cycle.
    always @(negedge clk) begin
        logic c_clk, c_tick, c_act;
        logic [31:0] e;
        for (int i = 0; i < 5; i++) begin
            c_clk  = (i < 4) ? clkout[i] : clkout4[0];
            c_tick = (i < 4) ? tick[i]   : tick4[0];
            c_act  = (i < 4) ? active[i] : active4[0];
            if (c_clk != prev_clk[i]) begin
                if (clk_q[i].size() == 0) check($sformatf("clk_unexpected_ch%0d", i), cyc, -1);
                else begin
                    e = clk_q[i].pop_front();
                    check($sformatf("clk_edge_ch%0d", i), cyc, int'(e));
                end
            end
            if (c_tick || (c_clk && !prev_clk[i]))
                check($sformatf("tick_vs_rise_ch%0d", i), int'(c_tick), int'(c_clk && !prev_clk[i]));
            if (c_act != prev_act[i]) begin
                if (act_q[i].size() == 0) check($sformatf("act_unexpected_ch%0d", i), cyc, -1);
                else begin
                    e = act_q[i].pop_front();
                    check($sformatf("act_edge_ch%0d", i), cyc, int'(e));
                end
            end
            prev_clk[i] = c_clk;
            prev_act[i] = c_act;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, t3;

        // Reset state, with enables already requested while reset is held
        repeat (3) @(negedge clk);
        ena = 4'hF;
        @(negedge clk);
        check("rst_clkout", int'(clkout), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_active", int'(active), 0);
        check("rst_clkout4", int'(clkout4), 0);

        // All channels, DIV=0: divide-by-2, four periods each
        t = cyc + 1;
        for (int ch = 0; ch < 4; ch++) begin
            push_start(ch, t);
            for (int k = 0; k < 4; k++) push_period(ch, t + 2 * k, 0);
            push_stop(ch, t + 8);
        end
        rst = 1'b0;
        wait_until(t);
        check("d0_active_after_start", int'(active), 15);
        check("d0_clkout_low_first", int'(clkout), 0);
        wait_until(t + 1);
        check("d0_tick_first", int'(tick), 15);
        wait_until(t + 6);
        ena = 4'h0;
        wait_until(t + 12);

        // Channel 1, DIV=3, ENA dropped while CLKOUT high
        div[15:8] = 8'd3;
        ena[1] = 1'b1;
        t = cyc + 1;
        push_start(1, t);
        for (int k = 0; k < 3; k++) push_period(1, t + 8 * k, 3);
        push_stop(1, t + 24);
        wait_until(t + 20);
        check("d3_high_at_drop", int'(clkout[1]), 1);
        ena[1] = 1'b0;
        wait_until(t + 22);
        check("d3_still_running", int'(active[1]), 1);
        check("d3_still_high", int'(clkout[1]), 1);
        wait_until(t + 30);

        // Channel 0, DIV=2 -> 5 mid low phase; brief ENA dip within period 1
        div[7:0] = 8'd2;
        ena[0] = 1'b1;
        t = cyc + 1;
        push_start(0, t);
        push_period(0, t, 2);
        push_period(0, t + 6, 2);
        push_period(0, t + 12, 5);
        push_stop(0, t + 24);
        wait_until(t + 1);
        ena[0] = 1'b0;
        wait_until(t + 3);
        ena[0] = 1'b1;
        wait_until(t + 7);
        div[7:0] = 8'd5;
        wait_until(t + 20);
        ena[0] = 1'b0;
        wait_until(t + 30);

        // DIV_W=4 instance, all-ones ratio: half-period 16
        div4 = 4'd15;
        ena4 = 1'b1;
        t = cyc + 1;
        push_start(4, t);
        push_period(4, t, 15);
        push_period(4, t + 32, 15);
        push_stop(4, t + 64);
        wait_until(t + 40);
        ena4 = 1'b0;
        wait_until(t + 70);

        // Channel 2, DIV=3, reset asserted mid high phase, then restart
        div[23:16] = 8'd3;
        ena[2] = 1'b1;
        t = cyc + 1;
        push_start(2, t);
        clk_q[2].push_back(t + 4);
        // reset drops both outputs asynchronously; the monitor sees it on the next sample
        clk_q[2].push_back(t + 6);
        push_stop(2, t + 6);
        wait_until(t + 5);
        check("rst_mid_pre_high", int'(clkout[2]), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_clkout", int'(clkout), 0);
        check("rst_mid_tick", int'(tick), 0);
        check("rst_mid_active", int'(active), 0);
        @(negedge clk);
        rst = 1'b0;
        t2 = cyc + 1;
        push_start(2, t2);
        push_period(2, t2, 3);
        push_stop(2, t2 + 8);
        wait_until(t2 + 4);
        ena[2] = 1'b0;
        wait_until(t2 + 12);

        // Channels 0/2 aligned, channel 3 offset by 3 and toggled independently
        div = {8'd1, 8'd1, 8'd0, 8'd1};
        ena[0] = 1'b1;
        ena[2] = 1'b1;
        t = cyc + 1;
        t3 = t + 3;
        for (int k = 0; k < 6; k++) begin
            push_period(0, t + 4 * k, 1);
            push_period(2, t + 4 * k, 1);
        end
        push_start(0, t);
        push_start(2, t);
        push_stop(0, t + 24);
        push_stop(2, t + 24);
        push_start(3, t3);
        push_period(3, t3, 1);
        push_period(3, t3 + 4, 1);
        push_stop(3, t3 + 8);
        push_start(3, t + 14);
        push_period(3, t + 14, 1);
        push_stop(3, t + 18);
        wait_until(t + 2);
        ena[3] = 1'b1;
        wait_until(t + 8);
        ena[3] = 1'b0;
        wait_until(t + 13);
        ena[3] = 1'b1;
        wait_until(t + 15);
        ena[3] = 1'b0;
        wait_until(t + 21);
        ena[0] = 1'b0;
        ena[2] = 1'b0;
        wait_until(t + 32);

        // Every expected edge must have been consumed
        for (int i = 0; i < 5; i++) begin
            check($sformatf("clk_q_empty_ch%0d", i), clk_q[i].size(), 0);
            check($sformatf("act_q_empty_ch%0d", i), act_q[i].size(), 0);
        end
        check("final_active", int'(active), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
